// File: rtl/sram_ctl_pkg.sv
// sram_ctl_pkg: FSM state encodings and sideband width shared by the SRAM-to-FIFO packet path.
package sram_ctl_pkg;
  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_SOP  = 3'd1,
    ST_DATA = 3'd2,
    ST_EOP  = 3'd3,
    ST_GAP  = 3'd4,
    ST_HALT = 3'd5
  } state_e;
  localparam int SB_W = 3;
endpackage

// File: rtl/pkt_tx.sv
// pkt_tx: frames an SRAM payload as SOP / data words / EOP FIFO writes from a (base, length) descriptor.
// Optional PKT_TX_STATS_EN adds a saturating pkt_cnt output.
module pkt_tx
  import sram_ctl_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 10,
  parameter int LEN_WIDTH  = 6,
  parameter int GAP_CYCLES = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_vld,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [LEN_WIDTH-1:0]  req_len,
  output logic                  req_rdy,
  output logic                  mem_rd_en,
  output logic [ADDR_WIDTH-1:0] mem_rd_addr,
  input  logic [DATA_WIDTH-1:0] mem_rd_data,
  output logic                  wr_sop,
  output logic                  wr_eop,
  output logic                  wr_vld,
  output logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  fifo_overflow,
  output logic                  busy,
`ifdef PKT_TX_STATS_EN
  output logic [15:0]           pkt_cnt,
`endif
  output logic                  err
);
  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [LEN_WIDTH-1:0]  rem_q, rem_d;
  logic [GW-1:0]         gap_q, gap_d;
  logic                  err_q, err_d;
  logic [SB_W-1:0]       sb;
`ifdef PKT_TX_STATS_EN
  logic [15:0]           cnt_q, cnt_d;
  assign cnt_d   = (state_q == ST_EOP && cnt_q != 16'hFFFF) ? cnt_q + 16'd1 : cnt_q;
  assign pkt_cnt = cnt_q;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      rem_q   <= '0;
      gap_q   <= '0;
      err_q   <= 1'b0;
`ifdef PKT_TX_STATS_EN
      cnt_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      rem_q   <= rem_d;
      gap_q   <= gap_d;
      err_q   <= err_d;
`ifdef PKT_TX_STATS_EN
      cnt_q   <= cnt_d;
`endif
    end
  end

  // addr_q always holds the next SRAM address to read; rem_q the words still to be emitted
  always_comb begin
    state_d = state_q;
    addr_d  = mem_rd_en ? addr_q + ADDR_WIDTH'(1) : addr_q;
    rem_d   = rem_q;
    gap_d   = gap_q;
    err_d   = err_q | fifo_overflow;
    case (state_q)
      ST_IDLE: begin
        if (req_vld && req_rdy) begin
          state_d = ST_SOP;
          addr_d  = req_addr;
          rem_d   = req_len;
        end else if (err_d) state_d = ST_HALT;
      end
      ST_SOP:  state_d = (rem_q == '0) ? ST_EOP : ST_DATA;
      ST_DATA: begin
        rem_d   = rem_q - LEN_WIDTH'(1);
        state_d = (rem_q == LEN_WIDTH'(1)) ? ST_EOP : ST_DATA;
      end
      ST_EOP: begin
        gap_d   = '0;
        state_d = err_d ? ST_HALT : (GAP_CYCLES == 0) ? ST_IDLE : ST_GAP;
      end
      ST_GAP: begin
        gap_d = gap_q + GW'(1);
        if (gap_q == GW'(GAP_CYCLES - 1)) state_d = err_d ? ST_HALT : ST_IDLE;
      end
      default: state_d = ST_HALT;
    endcase
  end

  always_comb begin
    mem_rd_en   = (state_q == ST_SOP && rem_q != '0) || (state_q == ST_DATA && rem_q > LEN_WIDTH'(1));
    mem_rd_addr = mem_rd_en ? addr_q : '0;
    sb          = {state_q == ST_SOP, state_q == ST_EOP, state_q == ST_DATA};
    wr_data     = sb[0] ? mem_rd_data : '0;
    req_rdy     = (state_q == ST_IDLE) && !err_q;
    busy        = state_q != ST_IDLE;
  end

  assign {wr_sop, wr_eop, wr_vld} = sb;
  assign err = err_q;
endmodule

// File: tb/tb_pkt_tx.sv
// tb_pkt_tx: scoreboard bench for pkt_tx; payload words and read addresses are queued at descriptor time.
module tb_pkt_tx;
  logic        clk = 1'b0;
  logic        rst_n, req_vld, req_rdy, mem_rd_en, wr_sop, wr_eop, wr_vld, fifo_overflow, busy, err;
  logic [9:0]  req_addr, mem_rd_addr;
  logic [5:0]  req_len;
  logic [15:0] mem_rd_data, wr_data;
`ifdef PKT_TX_STATS_EN
  logic [15:0] pkt_cnt;
`endif
  logic [15:0] mem [1024];
  logic [15:0] exp_data [$];
  logic [9:0]  exp_addr [$];
  logic [15:0] ed;
  logic [9:0]  ea;
  int vectors = 0;
  int errors  = 0;

  always #5 clk = ~clk;

  pkt_tx dut (
    .clk(clk), .rst_n(rst_n), .req_vld(req_vld), .req_addr(req_addr), .req_len(req_len),
    .req_rdy(req_rdy), .mem_rd_en(mem_rd_en), .mem_rd_addr(mem_rd_addr), .mem_rd_data(mem_rd_data),
    .wr_sop(wr_sop), .wr_eop(wr_eop), .wr_vld(wr_vld), .wr_data(wr_data),
    .fifo_overflow(fifo_overflow), .busy(busy),
`ifdef PKT_TX_STATS_EN
    .pkt_cnt(pkt_cnt),
`endif
    .err(err)
  );

  always @(posedge clk) mem_rd_data <= mem[mem_rd_addr];

  // scoreboard side: every emitted word and every read address is matched against the queues
  always @(negedge clk) begin
    if (rst_n) begin
      vectors++;
      if ((int'(wr_sop) + int'(wr_vld) + int'(wr_eop)) > 1 || (!wr_vld && wr_data !== 16'h0)) begin
        errors++;
        $display("FAIL framing: sop=%b vld=%b eop=%b data=%h, need at most one strobe and zero idle data",
                 wr_sop, wr_vld, wr_eop, wr_data);
      end
      if (wr_vld) begin
        vectors++;
        if (exp_data.size() == 0) begin
          errors++;
          $display("FAIL data_sb: got %h, no word expected", wr_data);
        end else begin
          ed = exp_data.pop_front();
          if (wr_data !== ed) begin
            errors++;
            $display("FAIL data_sb: got %h, expected %h", wr_data, ed);
          end
        end
      end
      if (mem_rd_en) begin
        vectors++;
        if (exp_addr.size() == 0) begin
          errors++;
          $display("FAIL addr_sb: read %h, no read expected", mem_rd_addr);
        end else begin
          ea = exp_addr.pop_front();
          if (mem_rd_addr !== ea) begin
            errors++;
            $display("FAIL addr_sb: read %h, expected %h", mem_rd_addr, ea);
          end
        end
      end
    end
  end

  task automatic push_desc(input logic [9:0] a, input int len);
    for (int i = 0; i < len; i++) begin
      exp_addr.push_back(10'(a + i));
      exp_data.push_back(mem[10'(a + i)]);
    end
    req_addr = a;
    req_len  = 6'(len);
    req_vld  = 1'b1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    #1 rst_n = 1'b1;
    exp_data.delete();
    exp_addr.delete();
  endtask

  task automatic test_reset();
    vectors++;
    if ({req_rdy, busy, err, wr_sop, wr_eop, wr_vld, mem_rd_en} !== 7'b1000000) begin
      errors++;
      $display("FAIL reset_ctl: rdy/busy/err/sop/eop/vld/rd=%b, expected 1000000",
               {req_rdy, busy, err, wr_sop, wr_eop, wr_vld, mem_rd_en});
    end
    vectors++;
    if (wr_data !== 16'h0 || mem_rd_addr !== 10'h0) begin
      errors++;
      $display("FAIL reset_bus: data=%h addr=%h, expected 0000/000", wr_data, mem_rd_addr);
    end
`ifdef PKT_TX_STATS_EN
    vectors++;
    if (pkt_cnt !== 16'd0) begin
      errors++;
      $display("FAIL reset_cnt: pkt_cnt=%0d, expected 0", pkt_cnt);
    end
`endif
  endtask

  task automatic test_basic();
    logic [3:0] e;
    push_desc(10'h010, 4);
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      req_vld = 1'b0;
      e = {k == 1, k >= 2 && k <= 5, k == 6, k >= 8};
      vectors++;
      if ({wr_sop, wr_vld, wr_eop, req_rdy} !== e) begin
        errors++;
        $display("FAIL basic_T%0d: sop/vld/eop/rdy=%b, expected %b", k, {wr_sop, wr_vld, wr_eop, req_rdy}, e);
      end
    end
  endtask

  task automatic test_len0();
    logic [4:0] e;
    push_desc(10'h020, 0);
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      req_vld = 1'b0;
      e = {k == 1, 1'b0, k == 2, k >= 4, 1'b0};
      vectors++;
      if ({wr_sop, wr_vld, wr_eop, req_rdy, mem_rd_en} !== e) begin
        errors++;
        $display("FAIL len0_T%0d: sop/vld/eop/rdy/rd=%b, expected %b", k,
                 {wr_sop, wr_vld, wr_eop, req_rdy, mem_rd_en}, e);
      end
    end
  endtask

  task automatic test_wrap();
    logic [2:0] e;
    push_desc(10'h3FF, 3);
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk);
      req_vld = 1'b0;
      e = {k == 5, k >= 7, busy};
      vectors++;
      if ({wr_eop, req_rdy, k <= 6} !== e) begin
        errors++;
        $display("FAIL wrap_T%0d: eop/rdy/busy=%b, expected %b", k, {wr_eop, req_rdy, busy}, {e[2:1], k <= 6});
      end
    end
    vectors++;
    if (exp_data.size() != 0 || exp_addr.size() != 0) begin
      errors++;
      $display("FAIL wrap_drain: %0d words %0d reads left, expected 0 0", exp_data.size(), exp_addr.size());
    end
  endtask

  task automatic test_overflow();
    logic [5:0] e;
    push_desc(10'h040, 5);
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      req_vld       = 1'b0;
      fifo_overflow = (k == 3);
      e = {k == 1, k >= 2 && k <= 6, k == 7, 1'b0, 1'b1, k >= 4};
      vectors++;
      if ({wr_sop, wr_vld, wr_eop, req_rdy, busy, err} !== e) begin
        errors++;
        $display("FAIL ovf_T%0d: sop/vld/eop/rdy/busy/err=%b, expected %b", k,
                 {wr_sop, wr_vld, wr_eop, req_rdy, busy, err}, e);
      end
    end
    vectors++;
    if (exp_data.size() != 0) begin
      errors++;
      $display("FAIL ovf_drain: %0d words unsent, expected 0", exp_data.size());
    end
    push_desc(10'h060, 2);
    repeat (4) @(negedge clk);
    vectors++;
    if ({req_rdy, wr_sop, busy, err} !== 4'b0011) begin
      errors++;
      $display("FAIL halt_hold: rdy/sop/busy/err=%b, expected 0011", {req_rdy, wr_sop, busy, err});
    end
    req_vld = 1'b0;
    do_reset();
    @(negedge clk);
    vectors++;
    if ({req_rdy, busy, err} !== 3'b100) begin
      errors++;
      $display("FAIL halt_reset: rdy/busy/err=%b, expected 100", {req_rdy, busy, err});
    end
  endtask

  task automatic test_reset_mid();
    logic [3:0] e;
    push_desc(10'h100, 5);
    repeat (3) begin
      @(negedge clk);
      req_vld = 1'b0;
    end
    @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    vectors++;
    if ({wr_sop, wr_vld, wr_eop, req_rdy, busy, mem_rd_en} !== 6'b000100 || wr_data !== 16'h0) begin
      errors++;
      $display("FAIL mid_reset: sop/vld/eop/rdy/busy/rd=%b data=%h, expected 000100 0000",
               {wr_sop, wr_vld, wr_eop, req_rdy, busy, mem_rd_en}, wr_data);
    end
    exp_data.delete();
    exp_addr.delete();
    push_desc(10'h200, 2);
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      req_vld = 1'b0;
      e = {k == 1, k == 2 || k == 3, k == 4, k >= 6};
      vectors++;
      if ({wr_sop, wr_vld, wr_eop, req_rdy} !== e) begin
        errors++;
        $display("FAIL after_reset_T%0d: sop/vld/eop/rdy=%b, expected %b", k, {wr_sop, wr_vld, wr_eop, req_rdy}, e);
      end
    end
  endtask

  task automatic test_back_to_back();
    int sop_t [$];
    int acc  = 0;
    int eops = 0;
    do_reset();
    @(negedge clk);
    repeat (3) push_desc(10'h050, 1);
    for (int c = 0; c < 40; c++) begin
      if (req_vld && acc == 3) req_vld = 1'b0;
      else if (req_vld && req_rdy) acc++;
      if (wr_sop) sop_t.push_back(c);
      if (wr_eop) eops++;
      @(negedge clk);
    end
    vectors++;
    if (sop_t.size() != 3 || eops != 3) begin
      errors++;
      $display("FAIL b2b_count: sops=%0d eops=%0d, expected 3 3", sop_t.size(), eops);
    end else begin
      vectors++;
      if (sop_t[1] - sop_t[0] != 5 || sop_t[2] - sop_t[1] != 5) begin
        errors++;
        $display("FAIL b2b_spacing: sop gaps %0d %0d, expected 5 5", sop_t[1] - sop_t[0], sop_t[2] - sop_t[1]);
      end
    end
`ifdef PKT_TX_STATS_EN
    vectors++;
    if (pkt_cnt !== 16'd3) begin
      errors++;
      $display("FAIL b2b_pkt_cnt: pkt_cnt=%0d, expected 3", pkt_cnt);
    end
`endif
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 16'(16'hA000 + i);
    rst_n         = 1'b0;
    req_vld       = 1'b0;
    req_addr      = '0;
    req_len       = '0;
    fifo_overflow = 1'b0;
    repeat (2) @(negedge clk);
    test_reset();
    #1 rst_n = 1'b1;
    @(negedge clk);
    test_basic();
    test_len0();
    test_wrap();
    test_overflow();
    test_reset_mid();
    test_back_to_back();
    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
